// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB word-addressed memory responder with wait states and byte-lane writes
// Define AHB_SLV_ERR_EN to answer illegal transfers with the two-cycle ERROR sequence.
module ahb_slave_mem #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned           WAIT_STATES = 1
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hburst,
  input  logic [2:0]            hsize,
  input  logic                  hwrite,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic [1:0]            hresp
);

  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
  localparam int unsigned DEC_LSB   = IDX_W + 2;
  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_ERR  = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1
`ifdef AHB_SLV_ERR_EN
    ,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   dph_valid_q, dph_valid_d;
  logic                   dph_write_q, dph_write_d;
  logic                   dph_legal_q, dph_legal_d;
  logic [2:0]             dph_size_q, dph_size_d;
  logic [1:0]             dph_lane_q, dph_lane_d;
  logic [IDX_W-1:0]       dph_idx_q, dph_idx_d;
  logic [2:0]             dph_burst_q, dph_burst_d;
  logic [DATA_WIDTH-1:0]  hrdata_q, hrdata_d;
  logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];

  logic                   in_range;
  logic                   size_ok;
  logic                   aligned;
  logic                   legal;
  logic                   accept;
  logic                   complete;
  logic                   err_state;
  logic                   mem_we;
  logic [NUM_LANES-1:0]   mem_be;
  logic                   unused_bits;

  // hburst is kept for visibility only; every beat is decoded from its own haddr.
  assign unused_bits = ^{dph_burst_q, htrans[0]};

  // Range check reduces to an upper-bit compare because BASE_ADDR is aligned to the memory size.
  always_comb begin
    in_range = (haddr[ADDR_WIDTH-1:DEC_LSB] == BASE_ADDR[ADDR_WIDTH-1:DEC_LSB]);
    size_ok  = 1'b1;
    aligned  = 1'b1;
    case (hsize)
      3'b000:  aligned = 1'b1;
      3'b001:  aligned = ~haddr[0];
      3'b010:  aligned = (haddr[1:0] == 2'b00);
      default: begin
        size_ok = 1'b0;
        aligned = 1'b0;
      end
    endcase
    legal = in_range && size_ok && aligned;
  end

  always_comb begin
    hready    = 1'b1;
    hresp     = RESP_OKAY;
    err_state = 1'b0;
    case (state_q)
      S_WAIT: hready = 1'b0;
`ifdef AHB_SLV_ERR_EN
      S_ERR1: begin
        hready    = 1'b0;
        hresp     = RESP_ERR;
        err_state = 1'b1;
      end
      S_ERR2: begin
        hresp     = RESP_ERR;
        err_state = 1'b1;
      end
`endif
      default: hready = 1'b1;
    endcase
  end

  assign accept   = hready && hsel && htrans[1];
  assign complete = (state_q == S_IDLE) && dph_valid_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dph_valid_d = dph_valid_q;
    dph_write_d = dph_write_q;
    dph_legal_d = dph_legal_q;
    dph_size_d  = dph_size_q;
    dph_lane_d  = dph_lane_q;
    dph_idx_d   = dph_idx_q;
    dph_burst_d = dph_burst_q;

    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`ifdef AHB_SLV_ERR_EN
      S_ERR1: state_d = S_ERR2;
`endif
      default: state_d = state_q;
    endcase

    // Any cycle with hready high retires the current data phase and may open the next one.
    if (hready) begin
      state_d     = S_IDLE;
      dph_valid_d = 1'b0;
      if (accept) begin
        dph_write_d = hwrite;
        dph_legal_d = legal;
        dph_size_d  = hsize;
        dph_lane_d  = haddr[1:0];
        dph_idx_d   = haddr[IDX_W+1:2];
        dph_burst_d = hburst;
        dph_valid_d = 1'b1;
        if (WAIT_STATES != 0) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_INIT;
        end
`ifdef AHB_SLV_ERR_EN
        if (!legal) begin
          dph_valid_d = 1'b0;
          state_d     = S_ERR1;
        end
`endif
      end
    end
  end

  always_comb begin
    hrdata = hrdata_q;
    if (complete && !dph_write_q) begin
      hrdata = dph_legal_q ? mem_q[dph_idx_q] : '0;
    end
    if (err_state) begin
      hrdata = '0;
    end
    hrdata_d = hrdata;
  end

  always_comb begin
    mem_we = complete && dph_write_q && dph_legal_q;
    case (dph_size_q)
      3'b000:  mem_be = 4'b0001 << dph_lane_q;
      3'b001:  mem_be = dph_lane_q[1] ? 4'b1100 : 4'b0011;
      default: mem_be = 4'b1111;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dph_valid_q <= 1'b0;
      dph_write_q <= 1'b0;
      dph_legal_q <= 1'b0;
      dph_size_q  <= '0;
      dph_lane_q  <= '0;
      dph_idx_q   <= '0;
      dph_burst_q <= '0;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dph_valid_q <= dph_valid_d;
      dph_write_q <= dph_write_d;
      dph_legal_q <= dph_legal_d;
      dph_size_q  <= dph_size_d;
      dph_lane_q  <= dph_lane_d;
      dph_idx_q   <= dph_idx_d;
      dph_burst_q <= dph_burst_d;
      hrdata_q    <= hrdata_d;
    end
  end

  // Storage has no reset; the write qualifier is built from reset flops, so an aborted write never lands.
  always_ff @(posedge hclk) begin
    if (mem_we) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (mem_be[b]) begin
          mem_q[dph_idx_q][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - directed and randomized checks of ahb_slave_mem against a byte-level memory model
module tb_ahb_slave_mem;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int          DEPTH  = 256;
  localparam int          NBYTES = DEPTH * 4;
`ifdef AHB_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    bit        wr;
    bit [1:0]  trans;
    bit [2:0]  burst;
    bit [2:0]  size;
    bit [31:0] addr;
    bit [31:0] wdata;
  } xfer_t;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel_a = 1'b0;
  logic        hsel_b = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hburst = 3'b000;
  logic [2:0]  hsize = 3'b000;
  logic        hwrite = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic [31:0] hwdata = 32'h0;
  logic [31:0] hrdata_a, hrdata_b;
  logic        hready_a, hready_b;
  logic [1:0]  hresp_a, hresp_b;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] last_rd = 32'h0;
  logic [7:0]  ref_mem [2][NBYTES];
  xfer_t       seq [$];

  always #5 hclk = ~hclk;

  ahb_slave_mem #(.WAIT_STATES(1)) u_dut_a (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel_a), .htrans(htrans), .hburst(hburst),
    .hsize(hsize), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hrdata(hrdata_a), .hready(hready_a), .hresp(hresp_a)
  );

  ahb_slave_mem #(.WAIT_STATES(0)) u_dut_b (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel_b), .htrans(htrans), .hburst(hburst),
    .hsize(hsize), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hrdata(hrdata_b), .hready(hready_b), .hresp(hresp_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
    if (a < BASE || a >= BASE + NBYTES) return 1'b0;
    if (s > 3'd2) return 1'b0;
    return (a % (32'd1 << s)) == 32'd0;
  endfunction

  function automatic logic [31:0] model_read(input int t, input logic [31:0] a);
    int off;
    off = int'((a - BASE) & ~32'd3);
    return {ref_mem[t][off+3], ref_mem[t][off+2], ref_mem[t][off+1], ref_mem[t][off]};
  endfunction

  task automatic model_write(input int t, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    int off;
    int lane;
    for (int i = 0; i < (1 << s); i++) begin
      off  = int'(a - BASE) + i;
      lane = (int'(a) + i) % 4;
      ref_mem[t][off] = d[8*lane +: 8];
    end
  endtask

  function automatic xfer_t mk(input bit wr, input bit [1:0] tr, input bit [31:0] a,
                               input bit [2:0] s, input bit [31:0] d);
    xfer_t x;
    x.wr = wr; x.trans = tr; x.burst = 3'b001; x.size = s; x.addr = a; x.wdata = d;
    return x;
  endfunction

  task automatic bus_idle();
    hsel_a = 1'b0; hsel_b = 1'b0; htrans = 2'b00; hwrite = 1'b0; hburst = 3'b000;
    hwdata = 32'h0;
  endtask

  // Drives the queued transfers as a pipelined AHB master and checks every cycle against the model.
  task automatic run_seq(input int t);
    int          ai, di, low, budget, limit;
    bit          rdy, lg, err;
    logic [1:0]  rsp;
    logic [31:0] rd;
    ai = 0; di = -1; low = 0; budget = 0;
    limit = 40 * seq.size() + 50;
    while ((ai < seq.size() || di >= 0) && budget < limit) begin
      budget++;
      if (ai < seq.size()) begin
        hsel_a = (t == 0); hsel_b = (t == 1);
        htrans = seq[ai].trans; hwrite = seq[ai].wr; haddr = seq[ai].addr;
        hsize = seq[ai].size; hburst = seq[ai].burst;
      end else begin
        hsel_a = 1'b0; hsel_b = 1'b0; htrans = 2'b00; hwrite = 1'b0;
      end
      hwdata = (di >= 0) ? seq[di].wdata : 32'h0;
      @(negedge hclk);
      rdy = (t == 0) ? hready_a : hready_b;
      rsp = (t == 0) ? hresp_a : hresp_b;
      rd  = (t == 0) ? hrdata_a : hrdata_b;
      if (di >= 0) begin
        lg  = is_legal(seq[di].addr, seq[di].size);
        err = !lg && ERR_EN;
        check("hresp", 32'(rsp), err ? 32'd1 : 32'd0);
        if (!rdy) begin
          low++;
        end else begin
          check("wait_cycles", 32'(low), err ? 32'd1 : ((t == 0) ? 32'd1 : 32'd0));
          if (!seq[di].wr || err)
            check("hrdata", rd, (lg && !seq[di].wr) ? model_read(t, seq[di].addr) : 32'h0);
          if (!seq[di].wr) last_rd = rd;
          if (seq[di].wr && lg) model_write(t, seq[di].addr, seq[di].size, seq[di].wdata);
        end
      end else begin
        check("idle_hready", 32'(rdy), 32'd1);
        check("idle_hresp", 32'(rsp), 32'd0);
      end
      @(posedge hclk);
      #1;
      if (rdy) begin
        di  = -1;
        low = 0;
        if (ai < seq.size()) begin
          if (seq[ai].trans[1]) di = ai;
          ai++;
        end
      end
    end
    check("seq_finished", 32'((ai >= seq.size()) && (di < 0)), 32'd1);
    bus_idle();
    seq.delete();
  endtask

  task automatic add_random(input int n);
    xfer_t   x;
    int      r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      x.trans = (r < 8) ? 2'b00 : (r < 14) ? 2'b01 : ($urandom_range(0, 1) ? 2'b10 : 2'b11);
      x.wr    = 1'($urandom_range(0, 1));
      x.burst = 3'($urandom_range(0, 7));
      x.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      x.wdata = $urandom;
      x.addr  = BASE + 32'($urandom_range(0, 15) * 4);
      r = $urandom_range(0, 19);
      if (r == 0)      x.addr = BASE - 32'd4;
      else if (r == 1) x.addr = BASE + NBYTES + 32'($urandom_range(0, 3) * 4);
      else if (r == 2) x.addr = x.addr + 32'($urandom_range(1, 3));
      else if (x.size <= 3'd2) x.addr = x.addr + 32'($urandom_range(0, 3) & ~((1 << x.size) - 1));
      seq.push_back(x);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    hresetn = 1'b0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check("reset_hready", 32'(hready_a), 32'd1);
    check("reset_hresp", 32'(hresp_a), 32'd0);
    check("reset_hrdata", hrdata_a, 32'h0);
    check("reset_hready_b", 32'(hready_b), 32'd1);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;

    for (int t = 0; t < 2; t++) begin
      for (int w = 0; w < DEPTH; w++)
        seq.push_back(mk(1'b1, 2'b10, BASE + 32'(w * 4), 3'd2, $urandom | 32'd1));
      run_seq(t);
    end

    seq.push_back(mk(1'b1, 2'b10, 32'h1004, 3'd2, 32'hDEAD_BEEF));
    seq.push_back(mk(1'b0, 2'b10, 32'h1004, 3'd2, 32'h0));
    run_seq(0);
    check("word_rw", last_rd, 32'hDEAD_BEEF);

    seq.push_back(mk(1'b1, 2'b10, 32'h1008, 3'd2, 32'h1122_3344));
    seq.push_back(mk(1'b1, 2'b10, 32'h100A, 3'd0, 32'h00AA_0000));
    seq.push_back(mk(1'b1, 2'b10, 32'h1008, 3'd1, 32'h0000_5566));
    seq.push_back(mk(1'b0, 2'b10, 32'h1008, 3'd2, 32'h0));
    run_seq(0);
    check("strobes", last_rd, 32'h11AA_5566);

    seq.push_back(mk(1'b1, 2'b10, 32'h0FFC, 3'd2, 32'h5A5A_5A5A));
    seq.push_back(mk(1'b0, 2'b10, 32'h1400, 3'd2, 32'h0));
    run_seq(0);
    check("oor_read", last_rd, 32'h0);

    seq.push_back(mk(1'b0, 2'b10, 32'h1002, 3'd2, 32'h0));
    seq.push_back(mk(1'b0, 2'b10, 32'h1000, 3'd3, 32'h0));
    seq.push_back(mk(1'b0, 2'b10, 32'h1004, 3'd2, 32'h0));
    run_seq(0);
    check("after_err2", last_rd, 32'hDEAD_BEEF);

    for (int i = 0; i < 4; i++) begin
      seq.push_back(mk(1'b1, (i == 0) ? 2'b10 : 2'b11, 32'h1010 + 32'(i * 4), 3'd2, 32'hA000_0000 + 32'(i)));
      seq[$].burst = 3'b011;
      if (i == 1) seq.push_back(mk(1'b1, 2'b01, 32'h1018, 3'd2, 32'hFFFF_FFFF));
    end
    for (int i = 0; i < 4; i++) begin
      seq.push_back(mk(1'b0, (i == 0) ? 2'b10 : 2'b11, 32'h1010 + 32'(i * 4), 3'd2, 32'h0));
      seq[$].burst = 3'b011;
      if (i == 2) seq.push_back(mk(1'b0, 2'b01, 32'h101C, 3'd2, 32'h0));
    end
    run_seq(1);
    check("burst_last", last_rd, 32'hA000_0003);

    seq.push_back(mk(1'b0, 2'b10, 32'h1020, 3'd2, 32'h0));
    run_seq(0);
    hsel_a = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h1020; hsize = 3'd2;
    @(posedge hclk);
    #1;
    bus_idle();
    hwdata = 32'hCAFE_F00D;
    @(negedge hclk);
    check("rst_in_wait", 32'(hready_a), 32'd0);
    #2;
    hresetn = 1'b0;
    #1;
    check("rst_hready", 32'(hready_a), 32'd1);
    check("rst_hresp", 32'(hresp_a), 32'd0);
    check("rst_hrdata", hrdata_a, 32'h0);
    @(negedge hclk);
    hresetn = 1'b1;
    hwdata = 32'h0;
    @(posedge hclk);
    #1;
    seq.push_back(mk(1'b0, 2'b10, 32'h1020, 3'd2, 32'h0));
    run_seq(0);
    check("rst_write_dropped", 32'(last_rd != 32'hCAFE_F00D), 32'd1);

    for (int t = 0; t < 2; t++) begin
      add_random(150);
      run_seq(t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
